ram_mdr_ctrl: RTL and testbench

RAM_MDR_CTRL -- requirements
Module: ram_mdr_ctrl

---
 rtl/ram_mdr_ctrl.sv | 110 +++++++++++
 tb/tb_ram_mdr_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mdr_ctrl.sv
// RAM controller with an address register (MAR) and a data register (MDR).
// Single-port RAM access through a small FSM: accept, perform, then report completion.
module ram_mdr_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_mar_pulse,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              en_ram,
    input  logic              wen_ram,
    input  logic [1:0]        mdr_ctrl,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              ram_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   mar_r;
    logic [ADDR_W-1:0]   mar_nxt_s;
    logic [DATA_W-1:0]   mdr_r;
    logic [DATA_W-1:0]   mdr_nxt_s;
    logic                mem_we_s;
    logic                busy_r;
    logic                ram_valid_r;
    logic [DATA_W-1:0]   mem_r [0:(2**ADDR_W)-1];

    // Next-state, register-update and RAM-write decode.
    always_comb begin
        next_state_s = state_r;
        mar_nxt_s    = mar_r;
        mdr_nxt_s    = mdr_r;
        mem_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // An explicit address load overrides the auto-increment.
                if (en_mar_pulse) begin
                    mar_nxt_s = addr_in;
                end else if (mdr_ctrl == 2'b10) begin
                    mar_nxt_s = mar_r + ADDR_W'(1);
                end else begin
                    mar_nxt_s = mar_r;
                end
                case (mdr_ctrl)
                    2'b01:   mdr_nxt_s = data_in;
                    2'b11:   mdr_nxt_s = {DATA_W{1'b0}};
                    default: mdr_nxt_s = mdr_r;
                endcase
                if (en_ram) begin
                    next_state_s = wen_ram ? WRITE : READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                mdr_nxt_s    = mem_r[mar_r];
                next_state_s = DONE;
            end
            WRITE: begin
                mem_we_s     = 1'b1;
                next_state_s = DONE;
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, address/data registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            mar_r       <= {ADDR_W{1'b0}};
            mdr_r       <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            ram_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            mar_r       <= mar_nxt_s;
            mdr_r       <= mdr_nxt_s;
            busy_r      <= (next_state_s != IDLE);
            ram_valid_r <= (next_state_s == DONE);
        end
    end

    // RAM array: never cleared, and a write is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_r[mar_r] <= mdr_r;
        end
    end

    assign ram_data  = mdr_r;
    assign busy      = busy_r;
    assign ram_valid = ram_valid_r;

endmodule

// File: tb/tb_ram_mdr_ctrl.sv
// Bench for ram_mdr_ctrl: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ram_mdr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_mar_pulse;
    logic [7:0]  addr_in;
    logic        en_ram;
    logic        wen_ram;
    logic [1:0]  mdr_ctrl;
    logic [15:0] data_in;
    logic [15:0] ram_data;
    logic        busy;
    logic        ram_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    ram_mdr_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_mar_pulse (en_mar_pulse),
        .addr_in      (addr_in),
        .en_ram       (en_ram),
        .wen_ram      (wen_ram),
        .mdr_ctrl     (mdr_ctrl),
        .data_in      (data_in),
        .ram_data     (ram_data),
        .busy         (busy),
        .ram_valid    (ram_valid)
    );

    always #5 clk = ~clk;

    // Reference model: registers, memory and the age of the access in flight
    // (0 = none, 1 = access cycle, 2 = completion cycle).
    logic [15:0] mem_m [0:255];
    logic [7:0]  mar_m;
    logic [15:0] mdr_m;
    int          age_m;
    logic        op_wr_m;

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (!rst) begin
            mar_m <= 8'h00;
            mdr_m <= 16'h0000;
            age_m <= 0;
        end else if (age_m == 0) begin
            if (en_mar_pulse)           mar_m <= addr_in;
            else if (mdr_ctrl == 2'b10) mar_m <= mar_m + 8'd1;
            if (mdr_ctrl == 2'b01)      mdr_m <= data_in;
            else if (mdr_ctrl == 2'b11) mdr_m <= 16'h0000;
            if (en_ram) begin
                age_m   <= 1;
                op_wr_m <= wen_ram;
            end
        end else if (age_m == 1) begin
            if (op_wr_m) mem_m[mar_m] <= mdr_m;
            else         mdr_m <= mem_m[mar_m];
            age_m <= 2;
        end else begin
            age_m <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model ram_data", {16'h0, ram_data}, {16'h0, mdr_m});
            chk("model busy", {31'h0, busy}, {31'h0, (age_m != 0)});
            chk("model ram_valid", {31'h0, ram_valid}, {31'h0, (age_m == 2)});
        end
    end

    task automatic clr();
        en_mar_pulse = 1'b0;
        addr_in      = 8'h00;
        en_ram       = 1'b0;
        wen_ram      = 1'b0;
        mdr_ctrl     = 2'b00;
        data_in      = 16'h0000;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        en_mar_pulse = 1'b1; addr_in = a; mdr_ctrl = 2'b01; data_in = d;
        en_ram = 1'b1; wen_ram = 1'b1;
        @(negedge clk);
        clr();
        repeat (2) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a);
        en_mar_pulse = 1'b1; addr_in = a; en_ram = 1'b1; wen_ram = 1'b0;
        @(negedge clk);
        clr();
        repeat (2) @(negedge clk);
    endtask

    int pulses;
    int first_at;
    int gap;

    initial begin
        rst = 1'b0;
        clr();
        repeat (3) @(negedge clk);
        chk("reset ram_data", {16'h0, ram_data}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset ram_valid", {31'h0, ram_valid}, 32'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        wr(8'h00, 16'hA5A5);
        wr(8'h30, 16'h0000);
        wr(8'h20, 16'h2020);
        wr(8'h40, 16'h4040);
        wr(8'h41, 16'h4141);

        // Write/read 0x05 with MDR clear in between; check latency.
        wr(8'h05, 16'h1234);
        mdr_ctrl = 2'b11;
        @(negedge clk);
        clr();
        chk("mdr clear", {16'h0, ram_data}, 32'h0);
        en_mar_pulse = 1'b1; addr_in = 8'h05; en_ram = 1'b1; wen_ram = 1'b0;
        @(negedge clk);
        clr();
        chk("read busy", {31'h0, busy}, 32'h1);
        chk("read early data", {16'h0, ram_data}, 32'h0);
        @(negedge clk);
        chk("read data k+2", {16'h0, ram_data}, 32'h1234);
        chk("read valid", {31'h0, ram_valid}, 32'h1);
        @(negedge clk);
        chk("valid one cycle", {31'h0, ram_valid}, 32'h0);
        chk("busy released", {31'h0, busy}, 32'h0);

        // Same-cycle load + write.
        wr(8'h10, 16'hBEEF);
        mdr_ctrl = 2'b11;
        @(negedge clk);
        clr();
        rd(8'h10);
        chk("same-cycle load write", {16'h0, ram_data}, 32'hBEEF);

        // MAR wrap 0xFF -> 0x00.
        en_mar_pulse = 1'b1; addr_in = 8'hFF;
        @(negedge clk);
        clr(); mdr_ctrl = 2'b10;
        @(negedge clk);
        clr(); en_ram = 1'b1;
        @(negedge clk);
        clr();
        repeat (2) @(negedge clk);
        chk("mar wrap", {16'h0, ram_data}, 32'hA5A5);

        // Load beats increment in the same cycle.
        en_mar_pulse = 1'b1; addr_in = 8'h40; mdr_ctrl = 2'b10;
        @(negedge clk);
        clr(); en_ram = 1'b1;
        @(negedge clk);
        clr();
        repeat (2) @(negedge clk);
        chk("load over inc", {16'h0, ram_data}, 32'h4040);

        // Commands ignored while busy.
        en_mar_pulse = 1'b1; addr_in = 8'h05; en_ram = 1'b1;
        @(negedge clk);
        clr();
        en_mar_pulse = 1'b1; addr_in = 8'h20; mdr_ctrl = 2'b01; data_in = 16'hFFFF;
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("busy ignore data", {16'h0, ram_data}, 32'h1234);
        en_ram = 1'b1;
        @(negedge clk);
        clr();
        repeat (2) @(negedge clk);
        chk("busy ignore mar", {16'h0, ram_data}, 32'h1234);

        // Reset during WRITE suppresses the write.
        en_mar_pulse = 1'b1; addr_in = 8'h30; mdr_ctrl = 2'b01; data_in = 16'hCAFE;
        en_ram = 1'b1; wen_ram = 1'b1;
        @(negedge clk);
        clr(); rst = 1'b0;
        @(negedge clk);
        chk("rst write busy", {31'h0, busy}, 32'h0);
        chk("rst write valid", {31'h0, ram_valid}, 32'h0);
        rst = 1'b1;
        rd(8'h30);
        chk("rst write no store", {16'h0, ram_data}, 32'h0);

        // Reset during READ leaves MDR cleared.
        en_mar_pulse = 1'b1; addr_in = 8'h05; en_ram = 1'b1;
        @(negedge clk);
        clr(); rst = 1'b0;
        @(negedge clk);
        chk("rst read mdr", {16'h0, ram_data}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Held read request for 6 cycles: two completions, 3 cycles apart.
        pulses = 0; first_at = -1; gap = 0;
        en_ram = 1'b1; wen_ram = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (ram_valid) begin
                pulses++;
                if (first_at < 0) first_at = i;
                else gap = i - first_at;
            end
        end
        clr();
        chk("held pulses", pulses, 32'd2);
        chk("held spacing", gap, 32'd3);
        chk("held data", {16'h0, ram_data}, 32'hA5A5);
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
